seq_divider: RTL and testbench

- Multi-cycle restoring divider, one quotient bit per clock; the subtractive counterpart of the combinational adder in the arithmetic library.
- Serves the RISC-V M-extension DIV/DIVU/REM/REMU path in the execute stage.
- Start/done handshake; the pipeline stalls on busy.
- Produces quotient and remainder together. Results follow RISC-V semantics, including the divide-by-zero and signed-overflow cases.

---
 rtl/seq_divider_if.sv | 30 +++
 rtl/seq_divider.sv | 153 +++++++++++++++
 tb/tb_seq_divider.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider_if
// Description : Start/done handshake and operand/result bundle for seq_divider.
// Revision    : 1.0
// ============================================================================
interface seq_divider_if #(
    parameter int NrOfBits = 32
);
    logic                start;
    logic                is_signed;
    logic [NrOfBits-1:0] DataA;
    logic [NrOfBits-1:0] DataB;
    logic                busy;
    logic                done;
    logic [NrOfBits-1:0] Quotient;
    logic [NrOfBits-1:0] Remainder;
    logic                DivByZero;

    modport master (
        output start, is_signed, DataA, DataB,
        input  busy, done, Quotient, Remainder, DivByZero
    );

    modport slave (
        input  start, is_signed, DataA, DataB,
        output busy, done, Quotient, Remainder, DivByZero
    );
endinterface
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Multi-cycle restoring divider, one quotient bit per clock,
//               RISC-V DIV/DIVU/REM/REMU semantics.
// Revision    : 1.0
// ============================================================================
module seq_divider #(
    parameter int NrOfBits = 32,
    parameter int CntBits  = 6
) (
    input  wire          clk,
    input  wire          rst_n,
    seq_divider_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [NrOfBits-1:0] MIN_NEG  = {1'b1, {(NrOfBits-1){1'b0}}};
    localparam logic [CntBits-1:0]  LAST_CNT = CntBits'(NrOfBits - 1);

    state_e              state_q;
    logic [CntBits-1:0]  cnt_q;
    logic [NrOfBits-1:0] dvd_q;
    logic [NrOfBits-1:0] dvs_q;
    logic [NrOfBits-1:0] rem_q;
    logic [NrOfBits-1:0] quo_q;
    logic                neg_quo_q;
    logic                neg_rem_q;
    logic                busy_q;
    logic                done_q;
    logic                dbz_q;
    logic [NrOfBits-1:0] quotient_q;
    logic [NrOfBits-1:0] remainder_q;

    logic [NrOfBits:0]   rem_sh;
    logic [NrOfBits-1:0] rem_diff;
    logic                rem_ge;
    logic [NrOfBits-1:0] rem_d;
    logic [NrOfBits-1:0] quo_d;
    logic [NrOfBits-1:0] dvd_d;

    logic                a_neg;
    logic                b_neg;
    logic [NrOfBits-1:0] abs_a;
    logic [NrOfBits-1:0] abs_b;
    logic                div_zero;
    logic                sgn_ovf;

    // The shifted partial remainder needs one extra bit: |B| may exceed 2^(N-1).
    always_comb begin
        rem_sh   = {rem_q, dvd_q[NrOfBits-1]};
        rem_ge   = (rem_sh >= {1'b0, dvs_q});
        rem_diff = rem_sh[NrOfBits-1:0] - dvs_q;
        rem_d    = rem_ge ? rem_diff : rem_sh[NrOfBits-1:0];
        quo_d    = {quo_q[NrOfBits-2:0], rem_ge};
        dvd_d    = {dvd_q[NrOfBits-2:0], 1'b0};
    end

    always_comb begin
        a_neg    = bus.is_signed & bus.DataA[NrOfBits-1];
        b_neg    = bus.is_signed & bus.DataB[NrOfBits-1];
        abs_a    = a_neg ? -bus.DataA : bus.DataA;
        abs_b    = b_neg ? -bus.DataB : bus.DataB;
        div_zero = (bus.DataB == '0);
        sgn_ovf  = bus.is_signed && (bus.DataA == MIN_NEG) && (bus.DataB == '1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        dvd_q     <= abs_a;
                        dvs_q     <= abs_b;
                        rem_q     <= '0;
                        quo_q     <= '0;
                        cnt_q     <= '0;
                        neg_quo_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        dbz_q     <= 1'b0;
                        if (div_zero) begin
                            quotient_q  <= '1;
                            remainder_q <= bus.DataA;
                            dbz_q       <= 1'b1;
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= DONE;
                        end else if (sgn_ovf) begin
                            quotient_q  <= bus.DataA;
                            remainder_q <= '0;
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= CALC;
                        end
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    dvd_q <= dvd_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    quotient_q  <= neg_quo_q ? -quo_q : quo_q;
                    remainder_q <= neg_rem_q ? -rem_q : rem_q;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                    state_q     <= DONE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.Quotient  = quotient_q;
    assign bus.Remainder = remainder_q;
    assign bus.DivByZero = dbz_q;
endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Scoreboard bench for seq_divider with a RISC-V division model.
// Revision    : 1.0
// ============================================================================
module tb_seq_divider;
    localparam int N        = 32;
    localparam int NORM_LAT = N + 2;

    logic clk = 1'b0;
    logic rst_n;

    seq_divider_if #(.NrOfBits(N)) bus ();

    seq_divider #(
        .NrOfBits(N),
        .CntBits (6)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        exp_t               e;
        logic signed [N-1:0] sa;
        logic signed [N-1:0] sbv;
        e.dbz = 1'b0;
        e.lat = NORM_LAT;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
            e.lat = 1;
        end else if (s && a == {1'b1, {(N-1){1'b0}}} && b == '1) begin
            e.q   = a;
            e.r   = '0;
            e.lat = 1;
        end else if (s) begin
            sa  = a;
            sbv = b;
            e.q = sa / sbv;
            e.r = sa % sbv;
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        bus.start     = 1'b1;
        bus.DataA     = a;
        bus.DataB     = b;
        bus.is_signed = s;
        sb.push_back(model(a, b, s));
    endtask

    // Call with start already driven; returns #1 after the edge that shows done.
    task automatic collect(input string name, input bit noise, output exp_t e);
        int cyc;
        int bcnt;
        bit got;
        cyc  = 0;
        bcnt = 0;
        got  = 1'b0;
        e    = '{q: '0, r: '0, dbz: 1'b0, lat: 0};
        while (!got && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) bus.start = 1'b0;
            if (noise && cyc >= 3 && cyc <= 6) begin
                bus.start     = ~bus.start;
                bus.DataA     = $urandom;
                bus.DataB     = $urandom;
                bus.is_signed = ~bus.is_signed;
            end
            if (bus.busy) bcnt++;
            if (bus.done) got = 1'b1;
        end
        if (sb.size() == 0) begin
            chk({name, ".scoreboard"}, 64'(0), 64'(1));
            return;
        end
        e = sb.pop_front();
        if (!got) begin
            chk({name, ".done_timeout"}, 64'(0), 64'(1));
            return;
        end
        chk({name, ".quotient"},  64'(bus.Quotient),  64'(e.q));
        chk({name, ".remainder"}, 64'(bus.Remainder), 64'(e.r));
        chk({name, ".divbyzero"}, 64'(bus.DivByZero), 64'(e.dbz));
        chk({name, ".latency"},   64'(cyc),           64'(e.lat));
        chk({name, ".busy_cyc"},  64'(bcnt),          64'((e.lat == 1) ? 0 : e.lat - 1));
    endtask

    task automatic after_check(input string name, input exp_t e);
        @(posedge clk);
        #1;
        chk({name, ".done_pulse"}, 64'(bus.done),     64'(0));
        chk({name, ".hold_q"},     64'(bus.Quotient), 64'(e.q));
        chk({name, ".hold_r"},     64'(bus.Remainder), 64'(e.r));
    endtask

    task automatic run(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic s, input bit noise);
        exp_t e;
        @(negedge clk);
        issue(a, b, s);
        collect(name, noise, e);
        after_check(name, e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t         e;
        logic [N-1:0] ra;
        logic [N-1:0] rb;

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.DataA     = '0;
        bus.DataB     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.busy",      64'(bus.busy),      64'(0));
        chk("reset.done",      64'(bus.done),      64'(0));
        chk("reset.quotient",  64'(bus.Quotient),  64'(0));
        chk("reset.remainder", 64'(bus.Remainder), 64'(0));
        chk("reset.divbyzero", 64'(bus.DivByZero), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run("udiv_100_7",    32'd100,        32'd7,          1'b0, 1'b0);
        run("sdiv_m7_2",     32'hFFFF_FFF9,  32'd2,          1'b1, 1'b0);
        run("sdiv_7_m2",     32'd7,          32'hFFFF_FFFE,  1'b1, 1'b0);
        run("div0_signed",   32'h1234_5678,  32'd0,          1'b1, 1'b0);
        run("div0_unsigned", 32'h1234_5678,  32'd0,          1'b0, 1'b0);
        run("sovf",          32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b0);
        run("uovf_path",     32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1'b0);
        run("big_divisor",   32'hFFFF_FFFE,  32'hFFFF_FFFF,  1'b0, 1'b0);
        run("noise_calc",    32'd1_000_003,  32'hFFFF_FFDB,  1'b1, 1'b1);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = (i % 2 == 1) ? $urandom : $urandom_range(1, 50);
            run($sformatf("rand%0d", i), ra, rb, (i % 3 != 0), 1'b0);
        end

        // Back-to-back: second start is driven during the DONE cycle.
        @(negedge clk);
        issue(32'd5000, 32'd9, 1'b0);
        collect("b2b_first", 1'b0, e);
        issue(32'd1000, 32'd3, 1'b0);
        collect("b2b_second", 1'b0, e);

        // Async reset in the 10th CALC cycle of a fresh division.
        @(negedge clk);
        issue(32'hDEAD_BEEF, 32'd3, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("rst_mid.busy_before", 64'(bus.busy),     64'(1));
        chk("rst_mid.q_held",      64'(bus.Quotient), 64'(e.q));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid.busy",      64'(bus.busy),      64'(0));
        chk("rst_mid.done",      64'(bus.done),      64'(0));
        chk("rst_mid.quotient",  64'(bus.Quotient),  64'(0));
        chk("rst_mid.remainder", 64'(bus.Remainder), 64'(0));
        chk("rst_mid.divbyzero", 64'(bus.DivByZero), 64'(0));
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run("after_rst", 32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
